// File: rtl/instr_loader_if.sv
// Program-store bus: load/run controls and write port from the board, fetch port to the control unit.
interface instr_loader_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3
);
    logic              load_mode;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              run_req;
    logic              step_req;
    logic [ADDR_W-1:0] pc_in;
    logic [DATA_W-1:0] inst_out;
    logic              core_en;
    logic [ADDR_W:0]   loaded_cnt;
    logic              full;
    logic              ovf;
    logic [1:0]        state_out;

    modport master (
        output load_mode, wr_valid, wr_data, run_req, step_req, pc_in,
        input  inst_out, core_en, loaded_cnt, full, ovf, state_out
    );

    modport slave (
        input  load_mode, wr_valid, wr_data, run_req, step_req, pc_in,
        output inst_out, core_en, loaded_cnt, full, ovf, state_out
    );
endinterface

// File: rtl/instr_loader.sv
// Writable instruction store with LOAD/RUN/STEP mode control for the core.
// Latency: inst_out is a 0-cycle read of store[pc_in]; writes and mode changes land on the next edge.
// Backpressure: none; writes while full are dropped and flagged on the sticky ovf.
module instr_loader #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    instr_loader_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        STEP = 2'b11
    } state_t;

    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   loaded_cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic              full;
    logic              ovf;
    logic              core_en;
    logic [DATA_W-1:0] store [DEPTH];

    assign cnt_inc = loaded_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            loaded_cnt <= '0;
            full       <= 1'b0;
            ovf        <= 1'b0;
            core_en    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_mode) begin
                        state      <= LOAD;
                        wr_ptr     <= '0;
                        loaded_cnt <= '0;
                        full       <= 1'b0;
                        ovf        <= 1'b0;
                    end else if (bus.run_req) begin
                        state   <= RUN;
                        core_en <= 1'b1;
                    end else if (bus.step_req) begin
                        state   <= STEP;
                        core_en <= 1'b1;
                    end
                end
                LOAD: begin
                    // A write on the cycle load_mode drops is still taken.
                    if (bus.wr_valid) begin
                        if (!full) begin
                            store[wr_ptr] <= bus.wr_data;
                            loaded_cnt    <= cnt_inc;
                            full          <= (cnt_inc == CNT_MAX);
                            if (cnt_inc != CNT_MAX) begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                    if (!bus.load_mode) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.load_mode) begin
                        state      <= LOAD;
                        core_en    <= 1'b0;
                        wr_ptr     <= '0;
                        loaded_cnt <= '0;
                        full       <= 1'b0;
                        ovf        <= 1'b0;
                    end else if (bus.run_req) begin
                        state   <= IDLE;
                        core_en <= 1'b0;
                    end
                end
                STEP: begin
                    state   <= IDLE;
                    core_en <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    core_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst_out   = store[bus.pc_in];
    assign bus.core_en    = core_en;
    assign bus.loaded_cnt = loaded_cnt;
    assign bus.full       = full;
    assign bus.ovf        = ovf;
    assign bus.state_out  = state;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: write table plus read-back scoreboard, and mode-sequencing corner cases.
module tb_instr_loader;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                exp_cnt;
        logic              exp_full;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_cnt;
    sb_t  sb[$];
    vec_t tbl[DEPTH];
    logic [DATA_W-1:0] first_word;

    instr_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_load();
        bus.load_mode = 1'b1;
        tick();
        exp_cnt = 0;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        if (exp_cnt < DEPTH) begin
            sb.push_back('{addr: ADDR_W'(exp_cnt), data: d});
            exp_cnt++;
        end
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pc_in = e.addr;
            #1;
            check("readback", 32'(bus.inst_out), 32'(e.data));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 0;
        reset = 1'b0;
        bus.load_mode = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.run_req   = 1'b0;
        bus.step_req  = 1'b0;
        bus.pc_in     = '0;

        for (int i = 0; i < DEPTH; i++) begin
            tbl[i].data     = DATA_W'(12'h9A0 + i * 37);
            tbl[i].exp_cnt  = i + 1;
            tbl[i].exp_full = (i == DEPTH - 1);
        end

        // Reset state
        tick();
        tick();
        reset = 1'b1;
        check("rst_state", 32'(bus.state_out), 32'd0);
        check("rst_core_en", 32'(bus.core_en), 32'd0);
        check("rst_cnt", 32'(bus.loaded_cnt), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.pc_in = ADDR_W'(a);
            #1;
            check("rst_store", 32'(bus.inst_out), 32'd0);
        end

        // Three-word load
        enter_load();
        check("load_state", 32'(bus.state_out), 32'd1);
        write_word(12'hA05);
        write_word(12'h3C1);
        write_word(12'h7FF);
        check("cnt3", 32'(bus.loaded_cnt), 32'd3);
        check("full3", 32'(bus.full), 32'd0);
        bus.load_mode = 1'b0;
        tick();
        check("idle_after_load", 32'(bus.state_out), 32'd0);
        bus.pc_in = 3'd1;
        #1;
        check("pc1_read", 32'(bus.inst_out), 32'h3C1);
        drain();

        // Full load with overflow; old word visible until the write edge
        enter_load();
        bus.pc_in = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = tbl[0].data;
                #1;
                check("old_word", 32'(bus.inst_out), 32'hA05);
            end
            write_word(tbl[i].data);
            check("tbl_cnt", 32'(bus.loaded_cnt), 32'(tbl[i].exp_cnt));
            check("tbl_full", 32'(bus.full), 32'(tbl[i].exp_full));
        end
        check("ovf_before", 32'(bus.ovf), 32'd0);
        write_word(12'h111);
        check("ovf_set", 32'(bus.ovf), 32'd1);
        check("cnt_sat", 32'(bus.loaded_cnt), 32'd8);
        bus.load_mode = 1'b0;
        tick();
        first_word = tbl[0].data;
        drain();
        enter_load();
        check("reentry_ovf", 32'(bus.ovf), 32'd0);
        check("reentry_cnt", 32'(bus.loaded_cnt), 32'd0);
        check("reentry_full", 32'(bus.full), 32'd0);
        bus.pc_in = '0;
        #1;
        check("reentry_keeps", 32'(bus.inst_out), 32'(first_word));
        bus.load_mode = 1'b0;
        tick();

        // Step and run
        bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        check("idle_wr_ignored", 32'(bus.loaded_cnt), 32'd0);
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        check("step_state", 32'(bus.state_out), 32'd3);
        check("step_en", 32'(bus.core_en), 32'd1);
        tick();
        check("step_back", 32'(bus.state_out), 32'd0);
        check("step_en_off", 32'(bus.core_en), 32'd0);
        tick();
        check("step_en_stay_off", 32'(bus.core_en), 32'd0);
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("run_en", 32'(bus.core_en), 32'd1);
            check("run_state", 32'(bus.state_out), 32'd2);
            tick();
        end
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        check("run_ignores_step", 32'(bus.state_out), 32'd2);
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        check("run_stop", 32'(bus.state_out), 32'd0);
        check("run_stop_en", 32'(bus.core_en), 32'd0);

        // Priority and RUN->LOAD, with a write on the exit cycle
        bus.load_mode = 1'b1;
        bus.run_req   = 1'b1;
        tick();
        bus.run_req = 1'b0;
        exp_cnt = 0;
        check("prio_load", 32'(bus.state_out), 32'd1);
        check("prio_en", 32'(bus.core_en), 32'd0);
        bus.load_mode = 1'b0;
        tick();
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        check("run_again", 32'(bus.state_out), 32'd2);
        enter_load();
        check("run_to_load", 32'(bus.state_out), 32'd1);
        check("run_to_load_en", 32'(bus.core_en), 32'd0);
        bus.load_mode = 1'b0;
        write_word(12'h5A5);
        check("exit_write_state", 32'(bus.state_out), 32'd0);
        check("exit_write_cnt", 32'(bus.loaded_cnt), 32'd1);
        drain();

        // Reset mid-LOAD
        enter_load();
        for (int i = 0; i < 4; i++) begin
            write_word(DATA_W'(12'h0F0 + i));
        end
        check("pre_rst_cnt", 32'(bus.loaded_cnt), 32'd4);
        sb.delete();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.load_mode = 1'b0;
        check("mid_rst_cnt", 32'(bus.loaded_cnt), 32'd0);
        check("mid_rst_state", 32'(bus.state_out), 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.pc_in = ADDR_W'(a);
            #1;
            check("mid_rst_store", 32'(bus.inst_out), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
